updown_counter_param: RTL and testbench



---
 rtl/counter_pkg.sv | 51 +++++
 rtl/counter_next_calc.sv | 59 +++++
 rtl/updown_counter_param.sv | 100 ++++++++++
 tb/tb_updown_counter_param.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// counter_pkg
//   Shared types and reference arithmetic for the up/down counter family.
//   cnt_mode_e   : boundary behaviour (wrap modulo MAX_VAL+1, or saturate).
//   cnt_result_t : {evt, value} returned by next_count.
//   next_count   : width-generic next-value computation. It works on
//                  CNT_CALC_W-bit operands, so it covers any counter of up
//                  to 64 bits. Callers zero-extend their operands.
package counter_pkg;

   typedef enum logic {CNT_WRAP = 1'b0, CNT_SAT = 1'b1} cnt_mode_e;

   localparam int unsigned CNT_CALC_W = 65;

   typedef struct packed {
      logic                  evt;
      logic [CNT_CALC_W-1:0] value;
   } cnt_result_t;

   function automatic cnt_result_t next_count(
      input logic [CNT_CALC_W-1:0] cur,
      input logic [CNT_CALC_W-1:0] step,
      input logic                  asc,
      input logic [CNT_CALC_W-1:0] max,
      input cnt_mode_e             mode
   );
      cnt_result_t           r;
      logic [CNT_CALC_W-1:0] sum;
      logic [CNT_CALC_W-1:0] modulus;
      modulus = max + 1'b1;
      sum     = cur + step;
      r.evt   = 1'b0;
      r.value = cur;
      if (asc) begin
         if (sum > max) begin
            r.evt   = 1'b1;
            r.value = (mode == CNT_SAT) ? max : sum - modulus;
         end else begin
            r.value = sum;
         end
      end else begin
         if (step > cur) begin
            r.evt   = 1'b1;
            r.value = (mode == CNT_SAT) ? '0 : cur + modulus - step;
         end else begin
            r.value = cur - step;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/counter_next_calc.sv
// counter_next_calc
//   Purely combinational next-value and boundary-event logic.
//   cur     : current count (0..max_val)
//   step    : amount to add or subtract
//   asc     : 1 = up, 0 = down
//   max_val : highest legal count
//   mode    : CNT_WRAP or CNT_SAT
//   nxt     : count after applying step
//   evt     : boundary crossed (or hit again while saturated)
//   Arithmetic is one bit wider than the count, so cur+step and
//   max_val+1 never overflow.
module counter_next_calc
   import counter_pkg::*;
#(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned STEP_W = 4
) (
   input  logic [WIDTH-1:0]  cur,
   input  logic [STEP_W-1:0] step,
   input  logic              asc,
   input  logic [WIDTH-1:0]  max_val,
   input  cnt_mode_e         mode,
   output logic [WIDTH-1:0]  nxt,
   output logic              evt
);

   logic [WIDTH:0] cur_x;
   logic [WIDTH:0] step_x;
   logic [WIDTH:0] max_x;
   logic [WIDTH:0] modulus;
   logic [WIDTH:0] sum;

   assign cur_x   = {1'b0, cur};
   assign step_x  = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
   assign max_x   = {1'b0, max_val};
   assign modulus = max_x + 1'b1;
   assign sum     = cur_x + step_x;

   always_comb begin
      nxt = cur;
      evt = 1'b0;
      if (asc) begin
         if (sum > max_x) begin
            evt = 1'b1;
            nxt = (mode == CNT_SAT) ? max_val : WIDTH'(sum - modulus);
         end else begin
            nxt = WIDTH'(sum);
         end
      end else begin
         if (step_x > cur_x) begin
            evt = 1'b1;
            nxt = (mode == CNT_SAT) ? '0 : WIDTH'(cur_x + modulus - step_x);
         end else begin
            nxt = WIDTH'(cur_x - step_x);
         end
      end
   end

endmodule

// File: rtl/updown_counter_param.sv
// updown_counter_param
//   Parametrised up/down counter with enable, variable step, programmable
//   modulus, wrap/saturate selection and boundary flags.
//   clk       : clock, all state updates on the rising edge
//   rst_s     : synchronous active-low reset
//   en        : count enable
//   load      : preload from din (clamped to MAX_VAL)
//   din       : preload value
//   asc       : 1 = count up, 0 = count down
//   step      : amount per enabled cycle
//   clr_flags : clears sticky ovf
//   dout      : registered count
//   tc        : registered pulse, high while dout shows a post-event value
//   ovf       : registered sticky boundary-event flag
//   at_max    : dout == MAX_VAL
//   at_min    : dout == 0
//   Edge priority: reset > load > en.
module updown_counter_param
   import counter_pkg::*;
#(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned STEP_W   = 4,
   parameter logic [63:0] MAX_VAL  = 64'((65'd1 << WIDTH) - 65'd1),
   parameter int unsigned SATURATE = 0
) (
   input  logic              clk,
   input  logic              rst_s,
   input  logic              en,
   input  logic              load,
   input  logic [WIDTH-1:0]  din,
   input  logic              asc,
   input  logic [STEP_W-1:0] step,
   input  logic              clr_flags,
   output logic [WIDTH-1:0]  dout,
   output logic              tc,
   output logic              ovf,
   output logic              at_max,
   output logic              at_min
);

   localparam logic [64:0]      RANGE_TOP = (65'd1 << WIDTH) - 65'd1;
   localparam logic [64:0]      STEP_TOP  = (65'd1 << STEP_W) - 65'd1;
   localparam logic [WIDTH-1:0] MAX_W     = MAX_VAL[WIDTH-1:0];
   localparam cnt_mode_e        MODE      = (SATURATE != 0) ? CNT_SAT : CNT_WRAP;

   // Parameter sanity: the range must fit the counter, and one modulus
   // correction must always be enough to bring a wrapped value back in range.
   if (WIDTH < 1 || WIDTH > 64) begin : g_chk_width
      $error("updown_counter_param: WIDTH must be 1..64");
   end
   if ({1'b0, MAX_VAL} > RANGE_TOP) begin : g_chk_max
      $error("updown_counter_param: MAX_VAL exceeds 2**WIDTH-1");
   end
   if (STEP_TOP > {1'b0, MAX_VAL} + 65'd1) begin : g_chk_step
      $error("updown_counter_param: 2**STEP_W-1 exceeds MAX_VAL+1");
   end

   logic [WIDTH-1:0] calc_nxt;
   logic             calc_evt;
   logic [WIDTH-1:0] din_clamped;

   counter_next_calc #(
      .WIDTH  (WIDTH),
      .STEP_W (STEP_W)
   ) u_calc (
      .cur     (dout),
      .step    (step),
      .asc     (asc),
      .max_val (MAX_W),
      .mode    (MODE),
      .nxt     (calc_nxt),
      .evt     (calc_evt)
   );

   assign din_clamped = (din > MAX_W) ? MAX_W : din;

   always_ff @(posedge clk) begin
      if (!rst_s) begin
         dout <= '0;
         tc   <= 1'b0;
         ovf  <= 1'b0;
      end else if (load) begin
         dout <= din_clamped;
         tc   <= 1'b0;
         ovf  <= ovf & ~clr_flags;
      end else if (en) begin
         dout <= calc_nxt;
         tc   <= calc_evt;
         // A new event beats a simultaneous clear.
         ovf  <= calc_evt | (ovf & ~clr_flags);
      end else begin
         tc   <= 1'b0;
         ovf  <= ovf & ~clr_flags;
      end
   end

   assign at_max = (dout == MAX_W);
   assign at_min = (dout == '0);

endmodule

// File: tb/tb_updown_counter_param.sv
// tb_updown_counter_param
//   Drives three instances (8-bit wrap MAX_VAL=9, 8-bit saturate MAX_VAL=9,
//   default 32-bit wrap) from shared inputs. Each expected result is pushed
//   when stimulus is applied and popped after the next rising edge.
//   Result packing: {dout[31:0], tc, ovf, at_max, at_min}.
module tb_updown_counter_param;
   import counter_pkg::*;

   localparam int RW = 36;

   logic        clk = 1'b0;
   logic        rst_s, en, load, asc, clr_flags;
   logic [31:0] din;
   logic [3:0]  step;

   logic [7:0]  dout_w, dout_s;
   logic [31:0] dout_d;
   logic        tc_w, ovf_w, amax_w, amin_w;
   logic        tc_s, ovf_s, amax_s, amin_s;
   logic        tc_d, ovf_d, amax_d, amin_d;

   logic [RW-1:0] exp_q[$];
   string         tag_q[$];
   int            sel_q[$];
   int            n_cmp = 0;
   int            n_err = 0;

   always #5 clk = ~clk;

   updown_counter_param #(.WIDTH(8), .STEP_W(3), .MAX_VAL(64'd9), .SATURATE(0)) u_wrap (
      .clk(clk), .rst_s(rst_s), .en(en), .load(load), .din(din[7:0]), .asc(asc),
      .step(step[2:0]), .clr_flags(clr_flags), .dout(dout_w), .tc(tc_w), .ovf(ovf_w),
      .at_max(amax_w), .at_min(amin_w));

   updown_counter_param #(.WIDTH(8), .STEP_W(3), .MAX_VAL(64'd9), .SATURATE(1)) u_sat (
      .clk(clk), .rst_s(rst_s), .en(en), .load(load), .din(din[7:0]), .asc(asc),
      .step(step[2:0]), .clr_flags(clr_flags), .dout(dout_s), .tc(tc_s), .ovf(ovf_s),
      .at_max(amax_s), .at_min(amin_s));

   updown_counter_param u_dflt (
      .clk(clk), .rst_s(rst_s), .en(en), .load(load), .din(din), .asc(asc),
      .step(step), .clr_flags(clr_flags), .dout(dout_d), .tc(tc_d), .ovf(ovf_d),
      .at_max(amax_d), .at_min(amin_d));

   task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got dout=%h tc/ovf/max/min=%b required dout=%h tc/ovf/max/min=%b",
                  tag, got[RW-1:4], got[3:0], exp[RW-1:4], exp[3:0]);
      end
   endtask

   function automatic logic [RW-1:0] observe(input int sel);
      case (sel)
         0:       return {24'd0, dout_w, tc_w, ovf_w, amax_w, amin_w};
         1:       return {24'd0, dout_s, tc_s, ovf_s, amax_s, amin_s};
         default: return {dout_d, tc_d, ovf_d, amax_d, amin_d};
      endcase
   endfunction

   // Inputs are already set by the caller; queue the expectation, take one
   // edge, then compare just after it.
   task automatic expect_edge(input int sel, input string tag, input logic [31:0] d,
                              input logic t, input logic o, input logic mx, input logic mn);
      logic [RW-1:0] e;
      exp_q.push_back({d, t, o, mx, mn});
      tag_q.push_back(tag);
      sel_q.push_back(sel);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check(tag_q.pop_front(), observe(sel_q.pop_front()), e);
   endtask

   task automatic drive(input logic r, input logic l, input logic e, input logic a,
                        input logic [3:0] s, input logic c, input logic [31:0] d);
      rst_s = r; load = l; en = e; asc = a; step = s; clr_flags = c; din = d;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "timeout");
   end

   initial begin : main
      logic [31:0] m_dout, m_next;
      logic        m_ovf, m_tc;
      cnt_result_t r;
      int          pick;

      drive(0, 1, 1, 1, 4'd1, 0, 32'd5);
      @(posedge clk); #1;

      // 1. reset wins over load/en; release loads 5
      expect_edge(0, "rst_hold",   0, 0, 0, 0, 1);
      expect_edge(0, "rst_hold2",  0, 0, 0, 0, 1);
      drive(1, 1, 1, 1, 4'd1, 0, 32'd5);
      expect_edge(0, "rst_release_load", 5, 0, 0, 0, 0);

      // 2. wrap up
      drive(1, 1, 0, 1, 4'd3, 0, 32'd8);
      expect_edge(0, "load8", 8, 0, 0, 0, 0);
      drive(1, 0, 1, 1, 4'd3, 0, 32'd0);
      expect_edge(0, "wrap_up_evt", 1, 1, 1, 0, 0);
      drive(1, 0, 1, 1, 4'd1, 0, 32'd0);
      expect_edge(0, "wrap_up_after", 2, 0, 1, 0, 0);

      // 3. wrap down, clear, clear vs event
      drive(1, 1, 0, 0, 4'd4, 0, 32'd1);
      expect_edge(0, "load1_keeps_ovf", 1, 0, 1, 0, 0);
      drive(1, 0, 1, 0, 4'd4, 0, 32'd0);
      expect_edge(0, "wrap_down_evt", 7, 1, 1, 0, 0);
      drive(1, 0, 0, 0, 4'd4, 1, 32'd0);
      expect_edge(0, "clr_no_evt", 7, 0, 0, 0, 0);
      drive(1, 1, 0, 0, 4'd1, 0, 32'd0);
      expect_edge(0, "load0", 0, 0, 0, 0, 1);
      drive(1, 0, 1, 0, 4'd1, 1, 32'd0);
      expect_edge(0, "clr_vs_evt", 9, 1, 1, 1, 0);

      // 4. saturate (reset mid-state first)
      drive(0, 0, 1, 1, 4'd5, 0, 32'd0);
      expect_edge(1, "sat_rst", 0, 0, 0, 0, 1);
      drive(1, 1, 0, 1, 4'd5, 0, 32'd7);
      expect_edge(1, "sat_load7", 7, 0, 0, 0, 0);
      drive(1, 0, 1, 1, 4'd5, 0, 32'd0);
      expect_edge(1, "sat_up1", 9, 1, 1, 1, 0);
      expect_edge(1, "sat_up2", 9, 1, 1, 1, 0);
      drive(1, 0, 1, 0, 4'd7, 0, 32'd0);
      expect_edge(1, "sat_dn1", 2, 0, 1, 0, 0);
      expect_edge(1, "sat_dn2", 0, 1, 1, 0, 1);
      expect_edge(1, "sat_dn3", 0, 1, 1, 0, 1);

      // 5. load clamp and hold on the wrap instance
      drive(0, 0, 0, 0, 4'd1, 0, 32'd0);
      expect_edge(0, "w_rst", 0, 0, 0, 0, 1);
      drive(1, 0, 1, 0, 4'd1, 0, 32'd0);
      expect_edge(0, "w_dn_from0", 9, 1, 1, 1, 0);
      drive(1, 1, 1, 0, 4'd1, 0, 32'd200);
      expect_edge(0, "clamp_ovf_kept", 9, 0, 1, 1, 0);
      drive(1, 0, 0, 1, 4'd3, 0, 32'd0);
      for (int i = 0; i < 3; i++) expect_edge(0, "hold_en0", 9, 0, 1, 1, 0);
      drive(1, 0, 1, 1, 4'd0, 0, 32'd0);
      expect_edge(0, "step0", 9, 0, 1, 1, 0);
      drive(1, 0, 0, 1, 4'd0, 1, 32'd0);
      expect_edge(0, "clr_hold", 9, 0, 0, 1, 0);
      drive(1, 1, 0, 1, 4'd0, 0, 32'd200);
      expect_edge(0, "clamp_no_ovf", 9, 0, 0, 1, 0);

      // 6. random regression on the 32-bit wrap instance
      drive(0, 0, 0, 0, 4'd0, 0, 32'd0);
      expect_edge(2, "d_rst", 0, 0, 0, 0, 1);
      m_dout = 0; m_ovf = 0;
      for (int i = 0; i < 1000; i++) begin
         pick = $urandom_range(0, 2);
         drive(1, ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) != 0),
               1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
               ($urandom_range(0, 7) == 0),
               (pick == 0) ? 32'($urandom_range(0, 15)) :
               (pick == 1) ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)) : $urandom);
         if (load) begin
            m_next = din;
            m_tc   = 1'b0;
            m_ovf  = m_ovf & ~clr_flags;
         end else if (en) begin
            r      = next_count({33'd0, m_dout}, {61'd0, step}, asc, 65'h0_FFFF_FFFF, CNT_WRAP);
            m_next = r.value[31:0];
            m_tc   = r.evt;
            m_ovf  = r.evt | (m_ovf & ~clr_flags);
         end else begin
            m_next = m_dout;
            m_tc   = 1'b0;
            m_ovf  = m_ovf & ~clr_flags;
         end
         m_dout = m_next;
         expect_edge(2, "rand", m_dout, m_tc, m_ovf, (m_dout == 32'hFFFF_FFFF), (m_dout == 32'd0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
